// File: rtl/masked_dom_and_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : masked_dom_and_pipe_if
//  Description : Operand / result handshake bundle for the masked DOM AND
//                pipeline. master = producer/consumer side, slave = pipeline.
//                  in_x, in_y   share k at [k*W +: W]
//                  in_rand      pairwise mask q at [q*W +: W]
//                  in_valid / in_ready    operand handshake
//                  out_z / out_valid / out_ready  result handshake
//  Revision    : 1.0  initial release
// ============================================================================
interface masked_dom_and_pipe_if #(
   parameter int NUM_SHARES = 2,
   parameter int W          = 4
);
   localparam int NQ = NUM_SHARES * (NUM_SHARES - 1) / 2;

   logic [NUM_SHARES*W-1:0] in_x;
   logic [NUM_SHARES*W-1:0] in_y;
   logic [NQ*W-1:0]         in_rand;
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_SHARES*W-1:0] out_z;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_x, in_y, in_rand, in_valid, out_ready,
      input  in_ready, out_z, out_valid
   );

   modport slave (
      input  in_x, in_y, in_rand, in_valid, out_ready,
      output in_ready, out_z, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/masked_dom_and_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : masked_dom_and_pipe
//  Description : N-share domain-oriented-masking bitwise AND, z = x & y.
//                Stage 1 registers inner terms x_i&y_i and re-masked cross
//                terms (x_i&y_j)^r{i,j}; stage 2 compresses each domain and
//                registers the result. valid/ready with backpressure.
//  Ports       : in_clock    rising-edge clock
//                in_reset_n  asynchronous active-low reset
//                bus         masked_dom_and_pipe_if.slave (operands, masks,
//                            result and both handshakes)
//  Revision    : 1.0  initial release
// ============================================================================
module masked_dom_and_pipe #(
   parameter int NUM_SHARES = 2,
   parameter int W          = 4
) (
   input  wire logic             in_clock,
   input  wire logic             in_reset_n,
   masked_dom_and_pipe_if.slave  bus
);

   function automatic int num_quad(input int n);
      return n * (n - 1) / 2;
   endfunction

   // Pairs {a,b}, a<b, are numbered row-major: (0,1),(0,2),..,(1,2),...
   function automatic int qindex(input int i, input int j, input int n);
      int a;
      int b;
      a = (i < j) ? i : j;
      b = (i < j) ? j : i;
      return a * n - (a * (a + 1)) / 2 + (b - a - 1);
   endfunction

   localparam int NQ = num_quad(NUM_SHARES);

   if (NUM_SHARES < 2) begin : g_bad_shares
      $error("masked_dom_and_pipe: NUM_SHARES must be >= 2");
   end

   logic [NUM_SHARES*W-1:0] w_x;
   logic [NUM_SHARES*W-1:0] w_y;
   logic [NQ*W-1:0]         w_rand;

   assign w_x    = bus.in_x;
   assign w_y    = bus.in_y;
   assign w_rand = bus.in_rand;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic r_s1_valid;
   logic r_s2_valid;
   logic w_s2_adv;
   logic w_s1_adv;
   logic w_accept;

   assign w_s2_adv     = ~r_s2_valid | bus.out_ready;
   assign w_s1_adv     = r_s1_valid & w_s2_adv;
   assign bus.in_ready = ~r_s1_valid | w_s2_adv;
   assign w_accept     = bus.in_valid & bus.in_ready;

   // ---------------------------------------------------------------------
   // Stage 1: term matrix. Diagonal = inner domain product, off-diagonal =
   // cross product blinded by the mask shared between domains i and j.
   // ---------------------------------------------------------------------
   logic [W-1:0] w_t [NUM_SHARES][NUM_SHARES];
   logic [W-1:0] r_t [NUM_SHARES][NUM_SHARES];

   for (genvar gi = 0; gi < NUM_SHARES; gi++) begin : g_row
      for (genvar gj = 0; gj < NUM_SHARES; gj++) begin : g_col
         if (gi == gj) begin : g_inner
            assign w_t[gi][gj] = w_x[gi*W +: W] & w_y[gi*W +: W];
         end else begin : g_cross
            localparam int Q = qindex(gi, gj, NUM_SHARES);
            assign w_t[gi][gj] = (w_x[gi*W +: W] & w_y[gj*W +: W]) ^ w_rand[Q*W +: W];
         end
      end
   end

   // Masks are only captured on accept; in_rand is ignored otherwise.
   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_s1_valid <= 1'b0;
         for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
               r_t[i][j] <= '0;
            end
         end
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_t        <= w_t;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: per-domain compression of registered terms only, so no
   // unmasked recombination can glitch through from the inputs.
   // ---------------------------------------------------------------------
   logic [NUM_SHARES*W-1:0] w_z;
   logic [NUM_SHARES*W-1:0] r_z;

   always_comb begin
      w_z = '0;
      for (int i = 0; i < NUM_SHARES; i++) begin
         for (int j = 0; j < NUM_SHARES; j++) begin
            w_z[i*W +: W] = w_z[i*W +: W] ^ r_t[i][j];
         end
      end
   end

   always_ff @(posedge in_clock or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_s2_valid <= 1'b0;
         r_z        <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_z        <= w_z;
         end else if (bus.out_ready) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_s2_valid;
   assign bus.out_z     = r_z;

endmodule
`default_nettype wire

// File: tb/tb_masked_dom_and_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_masked_dom_and_pipe
//  Description : Scoreboard bench for masked_dom_and_pipe, one 2-share and
//                one 3-share instance (W=4) sharing clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_masked_dom_and_pipe;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   masked_dom_and_pipe_if #(.NUM_SHARES(2), .W(4)) bus2 ();
   masked_dom_and_pipe_if #(.NUM_SHARES(3), .W(4)) bus3 ();

   masked_dom_and_pipe #(.NUM_SHARES(2), .W(4)) u_dut2 (
      .in_clock   (clk),
      .in_reset_n (rst_n),
      .bus        (bus2)
   );

   masked_dom_and_pipe #(.NUM_SHARES(3), .W(4)) u_dut3 (
      .in_clock   (clk),
      .in_reset_n (rst_n),
      .bus        (bus3)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference DOM AND: pair numbering built by enumerating pairs in order.
   function automatic logic [11:0] dom_ref(input int n, input logic [11:0] x,
                                           input logic [11:0] y, input logic [11:0] r);
      int         qi [3][3];
      int         k = 0;
      logic [11:0] z = '0;
      logic [3:0]  zi;
      for (int a = 0; a < n; a++) begin
         for (int b = a + 1; b < n; b++) begin
            qi[a][b] = k;
            qi[b][a] = k;
            k++;
         end
      end
      for (int i = 0; i < n; i++) begin
         zi = x[i*4 +: 4] & y[i*4 +: 4];
         for (int j = 0; j < n; j++) begin
            if (j != i) zi ^= (x[i*4 +: 4] & y[j*4 +: 4]) ^ r[qi[i][j]*4 +: 4];
         end
         z[i*4 +: 4] = zi;
      end
      return z;
   endfunction

   function automatic logic [3:0] fold(input int n, input logic [11:0] v);
      logic [3:0] f = '0;
      for (int i = 0; i < n; i++) f ^= v[i*4 +: 4];
      return f;
   endfunction

   logic [11:0] q2_z [$];
   logic [11:0] q3_z [$];
   logic [3:0]  q3_u [$];
   int          acc3 = 0;
   int          out3 = 0;
   logic [11:0] st3_z;
   bit          st3 = 1'b0;

   // Monitors sample 2 time units after the falling edge; the handshake they
   // observe completes on the following rising edge.
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (bus2.out_valid && bus2.out_ready) begin
            if (q2_z.size() == 0) chk("spurious_out2", {31'd0, bus2.out_valid}, 32'd0);
            else                  chk("z2", {24'd0, bus2.out_z}, {20'd0, q2_z.pop_front()});
         end
         if (bus2.in_valid && bus2.in_ready)
            q2_z.push_back(dom_ref(2, {4'd0, bus2.in_x}, {4'd0, bus2.in_y}, {8'd0, bus2.in_rand}));
      end
   end

   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         st3 = 1'b0;
      end else begin
         if (st3) begin
            chk("stall_valid", {31'd0, bus3.out_valid}, 32'd1);
            chk("stall_hold",  {20'd0, bus3.out_z},     {20'd0, st3_z});
         end
         st3   = bus3.out_valid && !bus3.out_ready;
         st3_z = bus3.out_z;
         if (bus3.out_valid && bus3.out_ready) begin
            if (q3_z.size() == 0) begin
               chk("spurious_out3", {31'd0, bus3.out_valid}, 32'd0);
            end else begin
               chk("z3",        {20'd0, bus3.out_z},          {20'd0, q3_z.pop_front()});
               chk("unmasked3", {28'd0, fold(3, bus3.out_z)}, {28'd0, q3_u.pop_front()});
               out3++;
            end
         end
         if (bus3.in_valid && bus3.in_ready) begin
            q3_z.push_back(dom_ref(3, bus3.in_x, bus3.in_y, bus3.in_rand));
            q3_u.push_back(fold(3, bus3.in_x) & fold(3, bus3.in_y));
            acc3++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int          base, idx, gaps, nr, cnt;
   logic [11:0] ox [3];
   logic [11:0] oy [3];

   initial begin
      bus2.in_x = '0; bus2.in_y = '0; bus2.in_rand = '0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
      bus3.in_x = '0; bus3.in_y = '0; bus3.in_rand = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid2", {31'd0, bus2.out_valid}, 32'd0);
      chk("rst_out_z2",     {24'd0, bus2.out_z},     32'd0);
      chk("rst_in_ready2",  {31'd0, bus2.in_ready},  32'd1);
      chk("rst_out_valid3", {31'd0, bus3.out_valid}, 32'd0);
      chk("rst_out_z3",     {20'd0, bus3.out_z},     32'd0);
      chk("rst_in_ready3",  {31'd0, bus3.in_ready},  32'd1);
      rst_n = 1'b1;

      // Two-share directed op: x = 3^9 = A, y = 5^3 = 6, r = 7.
      // z0 = (3&5)^(3&3)^7 = 5, z1 = (9&3)^(9&5)^7 = 7, z0^z1 = 2 = A&6.
      @(negedge clk);
      bus2.in_x = 8'h93; bus2.in_y = 8'h35; bus2.in_rand = 4'h7; bus2.in_valid = 1'b1;
      @(negedge clk);
      bus2.in_valid = 1'b0; bus2.in_rand = 4'hC;
      #1 chk("t1_lat1_valid", {31'd0, bus2.out_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("t1_lat2_valid", {31'd0, bus2.out_valid},       32'd1);
      chk("t1_z",          {24'd0, bus2.out_z},           32'h75);
      chk("t1_unmasked",   {28'd0, fold(2, {4'd0, bus2.out_z})}, 32'h2);

      // Back-to-back random throughput on the 3-share instance
      gaps = 0; nr = 0; base = out3;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         bus3.in_valid = 1'b1;
         bus3.in_x = 12'($urandom); bus3.in_y = 12'($urandom); bus3.in_rand = 12'($urandom);
         #1;
         if (!bus3.in_ready) nr++;
         if (k >= 2 && !bus3.out_valid) gaps++;
      end
      @(negedge clk);
      bus3.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("t2_ready_drops", nr, 0);
      chk("t2_gaps", gaps, 0);
      chk("t2_results", out3 - base, 1000);

      // Mask-to-pair mapping
      @(negedge clk);
      bus3.in_x = '0; bus3.in_y = '0; bus3.in_rand = 12'h00F; bus3.in_valid = 1'b1;
      @(negedge clk);
      bus3.in_rand = 12'hF00;
      @(negedge clk);
      bus3.in_valid = 1'b0; bus3.in_rand = 12'($urandom);
      #1 chk("t3_r0", {20'd0, bus3.out_z}, 32'h0FF);
      @(negedge clk);
      #1 chk("t3_r2", {20'd0, bus3.out_z}, 32'hFF0);
      repeat (2) @(negedge clk);

      // Backpressure: three ops offered against a stalled consumer; the
      // mask bus keeps changing while the pipeline refuses input.
      for (int k = 0; k < 3; k++) begin
         ox[k] = 12'($urandom);
         oy[k] = 12'($urandom);
      end
      @(negedge clk);
      bus3.out_ready = 1'b0; base = acc3;
      for (int c = 0; c < 5; c++) begin
         idx = acc3 - base;
         if (idx < 3) begin
            bus3.in_valid = 1'b1; bus3.in_x = ox[idx]; bus3.in_y = oy[idx];
         end else begin
            bus3.in_valid = 1'b0;
         end
         bus3.in_rand = 12'($urandom);
         @(negedge clk);
      end
      #1;
      chk("t4_accepted", acc3 - base, 2);
      chk("t4_in_ready", {31'd0, bus3.in_ready},  32'd0);
      chk("t4_out_valid", {31'd0, bus3.out_valid}, 32'd1);
      bus3.out_ready = 1'b1;
      for (int c = 0; c < 20 && q3_z.size() != 0; c++) begin
         @(negedge clk);
         idx = acc3 - base;
         if (idx < 3) begin
            bus3.in_valid = 1'b1; bus3.in_x = ox[idx]; bus3.in_y = oy[idx];
         end else begin
            bus3.in_valid = 1'b0;
         end
         bus3.in_rand = 12'($urandom);
      end
      chk("t4_accepted_all", acc3 - base, 3);
      chk("t4_drain", q3_z.size(), 0);

      // Random valid / ready with masks toggling every cycle
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus3.in_valid  = 1'($urandom_range(0, 1));
         bus3.out_ready = ($urandom_range(0, 3) != 0);
         bus3.in_x = 12'($urandom); bus3.in_y = 12'($urandom); bus3.in_rand = 12'($urandom);
      end
      @(negedge clk);
      bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;
      for (int c = 0; c < 20 && q3_z.size() != 0; c++) @(negedge clk);
      chk("t6_drain", q3_z.size(), 0);

      // Asynchronous reset with both stages full
      @(negedge clk);
      bus3.out_ready = 1'b0; bus3.in_valid = 1'b1;
      bus3.in_x = 12'($urandom); bus3.in_y = 12'($urandom); bus3.in_rand = 12'($urandom);
      @(negedge clk);
      bus3.in_x = 12'($urandom); bus3.in_y = 12'($urandom); bus3.in_rand = 12'($urandom);
      @(negedge clk);
      bus3.in_valid = 1'b0;
      #1;
      chk("t5_full_valid", {31'd0, bus3.out_valid}, 32'd1);
      chk("t5_s1_full",    {31'd0, bus3.in_ready},  32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid",    {31'd0, bus3.out_valid}, 32'd0);
      chk("t5_rst_z",        {20'd0, bus3.out_z},     32'd0);
      chk("t5_rst_in_ready", {31'd0, bus3.in_ready},  32'd1);
      q3_z.delete(); q3_u.delete(); q2_z.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus3.out_ready = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         bus3.in_rand = 12'($urandom);
         #1 if (bus3.out_valid) cnt++;
      end
      chk("t5_no_spurious", cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
